// File: rtl/fetch_unit.sv
// Instruction-fetch front end: holds the PC, computes PC+4 and the branch target,
// and reads the current instruction from a loadable word-organised memory.
module fetch_unit #(
   parameter int IMEM_WORDS = 256,
   parameter int AW         = $clog2(IMEM_WORDS)
) (
   input  logic          Clk,
   input  logic          En,
   input  logic          pc_write,
   input  logic          branch_taken,
   input  logic [63:0]   imm,
   input  logic          imem_we,
   input  logic [AW-1:0] imem_waddr,
   input  logic [31:0]   imem_wdata,
   output logic [63:0]   pc,
   output logic [63:0]   pc_plus4,
   output logic [63:0]   branch_target,
   output logic [63:0]   instruction
);

   logic [63:0] pc_q;
   logic [63:0] pc_d;
   logic [31:0] mem_q [IMEM_WORDS];
   logic        in_range;
   logic [31:0] fetch_word;

   always_comb begin
      pc_plus4      = pc_q + 64'd4;
      branch_target = pc_q + imm;
      pc_d          = pc_q;
      if (pc_write) begin
         pc_d = branch_taken ? branch_target : pc_plus4;
      end
   end

   // En low clears the PC at once; the memory is deliberately left untouched
   always_ff @(posedge Clk or negedge En) begin
      if (!En) begin
         pc_q <= 64'd0;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (En && imem_we) begin
         mem_q[imem_waddr] <= imem_wdata;
      end
   end

   // Anything above the memory window fetches zero; pc[1:0] never selects a word
   always_comb begin
      in_range    = (pc_q[63:AW+2] == '0);
      fetch_word  = in_range ? mem_q[pc_q[AW+1:2]] : 32'd0;
      instruction = En ? {32'd0, fetch_word} : 64'd0;
   end

   assign pc = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC/memory model pushes expected PC and
// instruction before each edge; they are popped and compared after it.
module tb_fetch_unit;

   localparam int WORDS = 256;
   localparam int AW    = 8;

   logic          Clk;
   logic          En;
   logic          pc_write;
   logic          branch_taken;
   logic [63:0]   imm;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic [63:0]   pc;
   logic [63:0]   pc_plus4;
   logic [63:0]   branch_target;
   logic [63:0]   instruction;

   logic [31:0] tb_mem [WORDS];
   logic [63:0] model_pc;
   logic [63:0] exp_pc_q [$];
   logic [63:0] exp_ins_q [$];
   logic [63:0] ep;
   logic [63:0] ei;
   int          n_checks;
   int          n_fail;

   fetch_unit #(.IMEM_WORDS(WORDS)) dut (
      .Clk(Clk), .En(En), .pc_write(pc_write), .branch_taken(branch_taken),
      .imm(imm), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .pc(pc), .pc_plus4(pc_plus4), .branch_target(branch_target),
      .instruction(instruction)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [63:0] model_ins(input logic [63:0] p);
      if (p[63:10] != '0) return 64'd0;
      return {32'd0, tb_mem[p[9:2]]};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic load_word(input int a, input logic [31:0] d);
      imem_waddr = AW'(a);
      imem_wdata = d;
      imem_we    = 1'b1;
      tick();
      imem_we    = 1'b0;
      tb_mem[a]  = d;
   endtask

   // Model the coming edge from the inputs as driven now and queue the result
   task automatic push_step();
      if (En && imem_we) tb_mem[imem_waddr] = imem_wdata;
      if (En && pc_write) model_pc = branch_taken ? model_pc + imm : model_pc + 64'd4;
      exp_pc_q.push_back(model_pc);
      exp_ins_q.push_back(model_ins(model_pc));
   endtask

   task automatic pop_exp();
      ep = exp_pc_q.pop_front();
      ei = exp_ins_q.pop_front();
   endtask

   task automatic test_reset();
      n_checks++; if (pc !== 64'd0) begin n_fail++; $display("FAIL reset_pc_initial got %h want 0", pc); end
      En = 1'b1;
      for (int i = 0; i < WORDS; i++) load_word(i, 32'd0);
      pc_write = 1'b1;
      tick();
      tick();
      imm = 64'h123;
      #2 En = 1'b0;
      #1;
      n_checks++; if (pc !== 64'd0) begin n_fail++; $display("FAIL reset_async_pc got %h want 0", pc); end
      n_checks++; if (instruction !== 64'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instruction); end
      n_checks++; if (pc_plus4 !== 64'd4) begin n_fail++; $display("FAIL reset_pc_plus4 got %h want 4", pc_plus4); end
      n_checks++; if (branch_target !== 64'h123) begin n_fail++; $display("FAIL reset_btarget got %h want 123", branch_target); end
      model_pc = 64'd0;
      pc_write = 1'b0;
      #1 En = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (pc !== 64'd0) begin n_fail++; $display("FAIL reset_hold_%0d got %h want 0", i, pc); end
      end
   endtask

   task automatic test_sequential();
      load_word(0, 32'h00500093);
      load_word(1, 32'h00A00113);
      load_word(2, 32'h002081B3);
      load_word(3, 32'h00000013);
      load_word(255, 32'hDEADBEEF);
      n_checks++; if (pc !== 64'd0) begin n_fail++; $display("FAIL seq_pc0 got %h want 0", pc); end
      n_checks++; if (instruction !== 64'h00500093) begin n_fail++; $display("FAIL seq_ins0 got %h want 00500093", instruction); end
      pc_write = 1'b1;
      branch_taken = 1'b0;
      for (int i = 1; i < 4; i++) begin
         push_step();
         tick();
         pop_exp();
         n_checks++; if (pc !== ep) begin n_fail++; $display("FAIL seq_pc_%0d got %h want %h", i, pc, ep); end
         n_checks++; if (instruction !== ei) begin n_fail++; $display("FAIL seq_ins_%0d got %h want %h", i, instruction, ei); end
         n_checks++; if (pc_plus4 !== ep + 64'd4) begin n_fail++; $display("FAIL seq_plus4_%0d got %h want %h", i, pc_plus4, ep + 64'd4); end
      end
      n_checks++; if (pc !== 64'hC) begin n_fail++; $display("FAIL seq_final got %h want c", pc); end
   endtask

   task automatic test_branch();
      branch_taken = 1'b1;
      imm = 64'hFFFF_FFFF_FFFF_FFFC;
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== 64'h8) begin n_fail++; $display("FAIL br_back4 got %h want 8", pc); end
      imm = 64'hFFFF_FFFF_FFFF_FFF8;
      #1;
      n_checks++; if (branch_target !== 64'd0) begin n_fail++; $display("FAIL br_target_neg got %h want 0", branch_target); end
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== ep) begin n_fail++; $display("FAIL br_to0 got %h want %h", pc, ep); end
      imm = 64'h10;
      #1;
      n_checks++; if (branch_target !== 64'h10) begin n_fail++; $display("FAIL br_target_pos got %h want 10", branch_target); end
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== 64'h10) begin n_fail++; $display("FAIL br_to10 got %h want 10", pc); end
      n_checks++; if (instruction !== ei) begin n_fail++; $display("FAIL br_ins10 got %h want %h", instruction, ei); end
   endtask

   task automatic test_hold();
      pc_write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         branch_taken = 1'($urandom_range(0, 1));
         imm = {$urandom, $urandom};
         push_step(); tick(); pop_exp();
         n_checks++; if (pc !== 64'h10) begin n_fail++; $display("FAIL hold_%0d got %h want 10", i, pc); end
      end
   endtask

   task automatic test_misalign();
      pc_write = 1'b1;
      branch_taken = 1'b1;
      imm = 64'hFFFF_FFFF_FFFF_FFF0;
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== 64'd0) begin n_fail++; $display("FAIL mis_to0 got %h want 0", pc); end
      imm = 64'd6;
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== 64'd6) begin n_fail++; $display("FAIL mis_pc got %h want 6", pc); end
      n_checks++; if (instruction !== 64'h00A00113) begin n_fail++; $display("FAIL mis_ins got %h want 00a00113", instruction); end
      n_checks++; if (pc_plus4 !== 64'd10) begin n_fail++; $display("FAIL mis_plus4 got %h want a", pc_plus4); end
   endtask

   task automatic test_bounds();
      branch_taken = 1'b1;
      imm = 64'h3FC - 64'd6;
      push_step(); tick(); pop_exp();
      n_checks++; if (instruction !== 64'hDEADBEEF) begin n_fail++; $display("FAIL bnd_last got %h want deadbeef", instruction); end
      imm = 64'd4;
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== 64'h400) begin n_fail++; $display("FAIL bnd_pc got %h want 400", pc); end
      n_checks++; if (instruction !== 64'd0) begin n_fail++; $display("FAIL bnd_out got %h want 0", instruction); end
      imm = 64'hFFFF_FFFF_FFFF_FFFC - 64'h400;
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL bnd_top got %h want fffffffffffffffc", pc); end
      n_checks++; if (pc_plus4 !== 64'd0) begin n_fail++; $display("FAIL bnd_wrap4 got %h want 0", pc_plus4); end
      n_checks++; if (instruction !== 64'd0) begin n_fail++; $display("FAIL bnd_top_ins got %h want 0", instruction); end
      branch_taken = 1'b0;
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== 64'd0) begin n_fail++; $display("FAIL bnd_wrap got %h want 0", pc); end
      n_checks++; if (instruction !== 64'h00500093) begin n_fail++; $display("FAIL bnd_wrap_ins got %h want 00500093", instruction); end
   endtask

   task automatic test_collision();
      pc_write = 1'b0;
      imem_waddr = '0;
      imem_wdata = 32'h12345678;
      imem_we = 1'b1;
      #1;
      n_checks++; if (instruction !== 64'h00500093) begin n_fail++; $display("FAIL col_before got %h want 00500093", instruction); end
      push_step(); tick(); pop_exp();
      imem_we = 1'b0;
      n_checks++; if (instruction !== 64'h12345678) begin n_fail++; $display("FAIL col_after got %h want 12345678", instruction); end
      n_checks++; if (instruction !== ei) begin n_fail++; $display("FAIL col_model got %h want %h", instruction, ei); end
   endtask

   task automatic test_reset_retention();
      pc_write = 1'b1;
      branch_taken = 1'b0;
      push_step(); tick(); pop_exp();
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== 64'h8) begin n_fail++; $display("FAIL ret_pre got %h want 8", pc); end
      #2 En = 1'b0;
      #1;
      n_checks++; if (pc !== 64'd0) begin n_fail++; $display("FAIL ret_async got %h want 0", pc); end
      model_pc = 64'd0;
      imem_waddr = '0;
      imem_wdata = 32'h00000BAD;
      imem_we = 1'b1;
      tick();
      imem_we = 1'b0;
      n_checks++; if (pc !== 64'd0) begin n_fail++; $display("FAIL ret_held got %h want 0", pc); end
      En = 1'b1;
      #1;
      n_checks++; if (instruction !== 64'h12345678) begin n_fail++; $display("FAIL ret_mem got %h want 12345678", instruction); end
      push_step(); tick(); pop_exp();
      n_checks++; if (pc !== 64'h4) begin n_fail++; $display("FAIL ret_resume got %h want 4", pc); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] target;
      for (int i = 0; i < 24; i++) begin
         pc_write = 1'($urandom_range(0, 3) != 0);
         branch_taken = 1'($urandom_range(0, 1));
         target = 64'($urandom_range(0, 260)) * 64'd4 + 64'($urandom_range(0, 3));
         imm = target - model_pc;
         imem_we = 1'($urandom_range(0, 2) == 0);
         imem_waddr = AW'($urandom_range(0, WORDS - 1));
         imem_wdata = $urandom;
         push_step(); tick(); pop_exp();
         imem_we = 1'b0;
         n_checks++; if (pc !== ep) begin n_fail++; $display("FAIL b2b_pc_%0d got %h want %h", i, pc, ep); end
         n_checks++; if (instruction !== ei) begin n_fail++; $display("FAIL b2b_ins_%0d got %h want %h", i, instruction, ei); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      model_pc = 64'd0;
      En = 1'b0;
      pc_write = 1'b0;
      branch_taken = 1'b0;
      imm = 64'd0;
      imem_we = 1'b0;
      imem_waddr = '0;
      imem_wdata = 32'd0;
      for (int i = 0; i < WORDS; i++) tb_mem[i] = 32'd0;
      #12;
      test_reset();
      test_sequential();
      test_branch();
      test_hold();
      test_misalign();
      test_bounds();
      test_collision();
      test_reset_retention();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
